// File: rtl/d16_encode_pkg.sv
// Shared d16 opcode map and field-layout classes; the opcode->format function
// is the single source of truth used by both encode and decode.
package d16_encode_pkg;

   localparam logic [7:0] D16_OP_ADD = 8'h01;
   localparam logic [7:0] D16_OP_SUB = 8'h02;
   localparam logic [7:0] D16_OP_SHL = 8'h03;
   localparam logic [7:0] D16_OP_SHR = 8'h04;
   localparam logic [7:0] D16_OP_OR  = 8'h05;
   localparam logic [7:0] D16_OP_AND = 8'h06;
   localparam logic [7:0] D16_OP_EQU = 8'h07;
   localparam logic [7:0] D16_OP_LTE = 8'h08;
   localparam logic [7:0] D16_OP_GTE = 8'h09;
   localparam logic [7:0] D16_OP_LT  = 8'h0A;
   localparam logic [7:0] D16_OP_GT  = 8'h0B;
   localparam logic [7:0] D16_OP_COP = 8'h0C;
   localparam logic [7:0] D16_OP_AFC = 8'h0D;
   localparam logic [7:0] D16_OP_LOD = 8'h0E;
   localparam logic [7:0] D16_OP_STR = 8'h0F;
   localparam logic [7:0] D16_OP_JMP = 8'h10;
   localparam logic [7:0] D16_OP_JMZ = 8'h11;
   localparam logic [7:0] D16_OP_JMR = 8'h12;
   localparam logic [7:0] D16_OP_STP = 8'h13;
   localparam logic [7:0] D16_OP_LOP = 8'h14;

   typedef enum logic [3:0] {
      D16_FMT_ILL,
      D16_FMT_RRR,
      D16_FMT_RR,
      D16_FMT_RI16,
      D16_FMT_A16R,
      D16_FMT_A16,
      D16_FMT_R,
      D16_FMT_STP,
      D16_FMT_LOP
   } d16_fmt_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HI,
      ST_LO
   } enc_state_e;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] c;
   } d16_fields_t;

   function automatic d16_fmt_e d16_fmt(input logic [7:0] op);
      d16_fmt_e f;
      case (op)
         D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_OR, D16_OP_AND,
         D16_OP_EQU, D16_OP_LTE, D16_OP_GTE, D16_OP_LT, D16_OP_GT:
                                 f = D16_FMT_RRR;
         D16_OP_COP:             f = D16_FMT_RR;
         D16_OP_AFC, D16_OP_LOD: f = D16_FMT_RI16;
         D16_OP_STR, D16_OP_JMZ: f = D16_FMT_A16R;
         D16_OP_JMP:             f = D16_FMT_A16;
         D16_OP_JMR:             f = D16_FMT_R;
         D16_OP_STP:             f = D16_FMT_STP;
         D16_OP_LOP:             f = D16_FMT_LOP;
         default:                f = D16_FMT_ILL;
      endcase
      return f;
   endfunction

   // Unsigned 8-bit field: upper byte clear.
   function automatic logic fits_u8(input logic [15:0] v);
      return v[15:8] == 8'h00;
   endfunction

   // Signed 8-bit field: upper byte is the sign extension of bit 7.
   function automatic logic fits_s8(input logic [15:0] v);
      return v[15:8] == {8{v[7]}};
   endfunction

endpackage

// File: rtl/d16_encode_pack.sv
// Combinational field-form -> 32-bit instruction packer with operand range check.
module d16_encode_pack
   import d16_encode_pkg::*;
(
   input  d16_fields_t fld_i,
   output logic [31:0] word_o,
   output logic        legal_o
);

   logic [7:0]  op;
   logic [15:0] a, b, c;
   logic        a8, b8, c8, a0, b0, c0;

   assign op = fld_i.op;
   assign a  = fld_i.a;
   assign b  = fld_i.b;
   assign c  = fld_i.c;
   assign a8 = fits_u8(a);
   assign b8 = fits_u8(b);
   assign c8 = fits_u8(c);
   assign a0 = (a == 16'h0000);
   assign b0 = (b == 16'h0000);
   assign c0 = (c == 16'h0000);

   always_comb begin
      word_o  = {op, 24'h000000};
      legal_o = 1'b0;
      case (d16_fmt(op))
         D16_FMT_RRR: begin
            legal_o = a8 & b8 & c8;
            word_o  = {op, a[7:0], b[7:0], c[7:0]};
         end
         D16_FMT_RR: begin
            legal_o = a8 & b8 & c0;
            word_o  = {op, a[7:0], b[7:0], 8'h00};
         end
         D16_FMT_RI16: begin
            legal_o = a8 & c0;
            word_o  = {op, a[7:0], b};
         end
         D16_FMT_A16R: begin
            legal_o = b8 & c0;
            word_o  = {op, a, b[7:0]};
         end
         D16_FMT_A16: begin
            legal_o = b0 & c0;
            word_o  = {op, a, 8'h00};
         end
         D16_FMT_R: begin
            legal_o = a0 & c0 & b8;
            word_o  = {op, b[7:0], 16'h0000};
         end
         D16_FMT_STP: begin
            legal_o = fits_s8(a) & b8 & c8;
            word_o  = {op, a[7:0], b[7:0], c[7:0]};
         end
         D16_FMT_LOP: begin
            legal_o = a8 & fits_s8(b) & c8;
            word_o  = {op, a[7:0], b[7:0], c[7:0]};
         end
         default: begin
            legal_o = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/d16_encode.sv
// d16 instruction encoder/loader: packs field-form instructions and writes them
// to instruction memory as two halfword beats (high half first).
module d16_encode
   import d16_encode_pkg::*;
#(
   parameter int AW  = 16,
   parameter int ECW = 8
) (
   input  logic           sys_clk,
   input  logic           sys_rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     in_op,
   input  logic [15:0]    in_a,
   input  logic [15:0]    in_b,
   input  logic [15:0]    in_c,
   input  logic           adr_load,
   input  logic [AW-1:0]  adr_base,
   output logic [AW-1:0]  mem_adr,
   output logic [15:0]    mem_dat,
   output logic           mem_we,
   input  logic           mem_ack,
   output logic           done,
   output logic           err,
   output logic [ECW-1:0] err_cnt,
   output logic [15:0]    instr_cnt
);

   enc_state_e     state_q, state_d;
   logic [AW-1:0]  ptr_q, ptr_d;
   logic [15:0]    lo_q, lo_d;
   logic [AW-1:0]  adr_q, adr_d;
   logic [15:0]    dat_q, dat_d;
   logic           we_q, we_d;
   logic           done_q, done_d;
   logic           err_q, err_d;
   logic [ECW-1:0] ecnt_q, ecnt_d;
   logic [15:0]    icnt_q, icnt_d;

   d16_fields_t fld;
   logic [31:0] word;
   logic        legal;
   logic        accept;
   logic [AW-1:0] ptr_adv;

   assign fld = '{op: in_op, a: in_a, b: in_b, c: in_c};

   d16_encode_pack u_pack (
      .fld_i   (fld),
      .word_o  (word),
      .legal_o (legal)
   );

   // Ready in the final LO-ack cycle lets a new instruction chain straight into HI.
   assign in_ready = ((state_q == ST_IDLE) | ((state_q == ST_LO) & mem_ack)) & ~adr_load;
   assign accept   = in_valid & in_ready;
   assign ptr_adv  = adr_load ? adr_base : ptr_q + AW'(2);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      lo_d    = lo_q;
      adr_d   = adr_q;
      dat_d   = dat_q;
      we_d    = we_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ecnt_d  = ecnt_q;
      icnt_d  = icnt_q;

      case (state_q)
         ST_IDLE: begin
            if (adr_load) ptr_d = adr_base;
         end
         ST_HI: begin
            if (mem_ack) begin
               state_d = ST_LO;
               adr_d   = ptr_q + AW'(1);
               dat_d   = lo_q;
            end
         end
         ST_LO: begin
            if (mem_ack) begin
               state_d = ST_IDLE;
               we_d    = 1'b0;
               ptr_d   = ptr_adv;
               done_d  = 1'b1;
               icnt_d  = icnt_q + 16'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            we_d    = 1'b0;
         end
      endcase

      // accept implies ~adr_load, so ptr_d here is the address of the new high half.
      if (accept) begin
         if (legal) begin
            state_d = ST_HI;
            we_d    = 1'b1;
            adr_d   = ptr_d;
            dat_d   = word[31:16];
            lo_d    = word[15:0];
         end else begin
            err_d = 1'b1;
            if (ecnt_q != '1) ecnt_d = ecnt_q + ECW'(1);
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         lo_q    <= '0;
         adr_q   <= '0;
         dat_q   <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         lo_q    <= lo_d;
         adr_q   <= adr_d;
         dat_q   <= dat_d;
         we_q    <= we_d;
         done_q  <= done_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
         icnt_q  <= icnt_d;
      end
   end

   assign mem_adr   = adr_q;
   assign mem_dat   = dat_q;
   assign mem_we    = we_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_cnt   = ecnt_q;
   assign instr_cnt = icnt_q;

endmodule

// File: tb/tb_d16_encode.sv
// Bench for d16_encode: directed steps plus random instructions checked against
// an arithmetic reference encoder and an expected-write scoreboard.
module tb_d16_encode;
   import d16_encode_pkg::*;

   logic        clk;
   logic        sys_rst_n;
   logic        in_valid, in_ready;
   logic [7:0]  in_op;
   logic [15:0] in_a, in_b, in_c;
   logic        adr_load;
   logic [15:0] adr_base;
   logic [15:0] mem_adr, mem_dat;
   logic        mem_we, mem_ack;
   logic        done, err;
   logic [7:0]  err_cnt;
   logic [15:0] instr_cnt;

   logic        in_valid2, in_ready2, adr_load2, mem_ack2;
   logic [15:0] adr_base2, mem_adr2, mem_dat2, instr_cnt2;
   logic        mem_we2, done2, err2;
   logic [1:0]  err_cnt2;

   int checks = 0;
   int errors = 0;

   d16_encode #(.AW(16), .ECW(8)) dut (
      .sys_clk(clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .adr_load(adr_load), .adr_base(adr_base), .mem_adr(mem_adr), .mem_dat(mem_dat),
      .mem_we(mem_we), .mem_ack(mem_ack), .done(done), .err(err),
      .err_cnt(err_cnt), .instr_cnt(instr_cnt)
   );

   d16_encode #(.AW(16), .ECW(2)) dut2 (
      .sys_clk(clk), .sys_rst_n(sys_rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .adr_load(adr_load2), .adr_base(adr_base2), .mem_adr(mem_adr2), .mem_dat(mem_dat2),
      .mem_we(mem_we2), .mem_ack(mem_ack2), .done(done2), .err(err2),
      .err_cnt(err_cnt2), .instr_cnt(instr_cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard / model state
   logic [31:0] exp_q[$];
   logic [31:0] got_q[$];
   logic [15:0] ptr_m;
   int          n_done_m, n_err_m, ecnt_m;
   int          done_seen, err_seen;
   int          ack_delay;
   int          run_len, max_run;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // Reference encoder written from the field rules with plain arithmetic.
   function automatic void ref_encode(input logic [7:0] op, input logic [15:0] a,
                                      input logic [15:0] b, input logic [15:0] c,
                                      output bit ok, output logic [31:0] w);
      int sa, sb;
      bit ua, ub, uc, za, zb, zc, s8a, s8b;
      logic [31:0] top, ab, bb, cb, a16, b16;
      ua = a < 256;  ub = b < 256;  uc = c < 256;
      za = a == 0;   zb = b == 0;   zc = c == 0;
      sa = int'($signed(a)); sb = int'($signed(b));
      s8a = (sa >= -128) && (sa <= 127);
      s8b = (sb >= -128) && (sb <= 127);
      top = 32'(op) * 32'h0100_0000;
      ab = 32'(a) % 256; bb = 32'(b) % 256; cb = 32'(c) % 256;
      a16 = 32'(a); b16 = 32'(b);
      ok = 0;
      w  = top;
      case (op)
         D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_OR, D16_OP_AND,
         D16_OP_EQU, D16_OP_LTE, D16_OP_GTE, D16_OP_LT, D16_OP_GT: begin
            ok = ua && ub && uc; w = top + ab * 65536 + bb * 256 + cb; end
         D16_OP_COP: begin ok = ua && ub && zc; w = top + ab * 65536 + bb * 256; end
         D16_OP_AFC, D16_OP_LOD: begin ok = ua && zc; w = top + ab * 65536 + b16; end
         D16_OP_STR, D16_OP_JMZ: begin ok = ub && zc; w = top + a16 * 256 + bb; end
         D16_OP_JMP: begin ok = zb && zc; w = top + a16 * 256; end
         D16_OP_JMR: begin ok = za && zc && ub; w = top + bb * 65536; end
         D16_OP_STP: begin ok = s8a && ub && uc; w = top + ab * 65536 + bb * 256 + cb; end
         D16_OP_LOP: begin ok = ua && s8b && uc; w = top + ab * 65536 + bb * 256 + cb; end
         default: ok = 0;
      endcase
   endfunction

   // Memory slave: acks after ack_delay wait cycles, logs beats, checks hold stability.
   initial begin : slave
      int wcnt;
      bit pw;
      logic [15:0] padr, pdat;
      mem_ack = 0; wcnt = 0; pw = 0; padr = 0; pdat = 0;
      run_len = 0; max_run = 0; done_seen = 0; err_seen = 0;
      forever begin
         @(negedge clk);
         if (!sys_rst_n) begin
            mem_ack = 0; wcnt = 0; pw = 0; run_len = 0;
         end else begin
            if (pw) begin
               chk("hold_we", 32'(mem_we), 32'd1);
               chk("hold_adr", 32'(mem_adr), 32'(padr));
               chk("hold_dat", 32'(mem_dat), 32'(pdat));
            end
            if (mem_we && wcnt >= ack_delay) begin
               mem_ack = 1; wcnt = 0;
               got_q.push_back({mem_adr, mem_dat});
            end else if (mem_we) begin
               mem_ack = 0; wcnt++;
            end else begin
               mem_ack = 0; wcnt = 0;
            end
            pw = mem_we && !mem_ack; padr = mem_adr; pdat = mem_dat;
            run_len = mem_we ? run_len + 1 : 0;
            if (run_len > max_run) max_run = run_len;
            if (done) done_seen++;
            if (err) err_seen++;
         end
      end
   end

   task automatic send(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c);
      bit ok; logic [31:0] w; int n;
      ref_encode(op, a, b, c, ok, w);
      if (ok) begin
         exp_q.push_back({ptr_m, w[31:16]});
         exp_q.push_back({ptr_m + 16'd1, w[15:0]});
         ptr_m = ptr_m + 16'd2;
         n_done_m++;
      end else begin
         n_err_m++;
         if (ecnt_m < 255) ecnt_m++;
      end
      n = 0;
      while (1) begin
         @(negedge clk);
         in_valid = 1; in_op = op; in_a = a; in_b = b; in_c = c;
         #1;
         if (in_ready || n > 200) break;
         n++;
      end
      chk("in_ready_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1 in_valid = 0;
   endtask

   task automatic load(input logic [15:0] base);
      @(negedge clk); adr_load = 1; adr_base = base;
      @(posedge clk); #1 adr_load = 0;
      ptr_m = base;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin @(negedge clk); n++; end while (mem_we && n < 500);
      chk("idle_reached", 32'(mem_we), 32'd0);
      @(negedge clk);
   endtask

   task automatic check_all(input string tag);
      int n;
      wait_idle();
      chk({tag, "_nwrites"}, 32'(got_q.size()), 32'(exp_q.size()));
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_write"}, got_q[i], exp_q[i]);
      chk({tag, "_done"}, 32'(done_seen), 32'(n_done_m));
      chk({tag, "_err"}, 32'(err_seen), 32'(n_err_m));
      chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(ecnt_m));
      chk({tag, "_instr_cnt"}, 32'(instr_cnt), 32'(n_done_m % 65536));
      got_q.delete(); exp_q.delete();
   endtask

   function automatic logic [15:0] rnd_opnd();
      case ($urandom_range(0, 4))
         0: return 16'h0000;
         1, 2: return 16'($urandom_range(0, 255));
         3: return 16'hFF80 | 16'($urandom_range(0, 127));
         default: return 16'($urandom);
      endcase
   endfunction

   logic [7:0] op_tab [22];

   initial begin
      op_tab = '{D16_OP_ADD, D16_OP_SUB, D16_OP_SHL, D16_OP_SHR, D16_OP_OR, D16_OP_AND,
                 D16_OP_EQU, D16_OP_LTE, D16_OP_GTE, D16_OP_LT, D16_OP_GT, D16_OP_COP,
                 D16_OP_AFC, D16_OP_LOD, D16_OP_STR, D16_OP_JMP, D16_OP_JMZ, D16_OP_JMR,
                 D16_OP_STP, D16_OP_LOP, 8'h00, 8'hEE};
      sys_rst_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_c = 0;
      adr_load = 0; adr_base = 0; ack_delay = 0;
      in_valid2 = 0; adr_load2 = 0; adr_base2 = 0; mem_ack2 = 0;
      ptr_m = 0; n_done_m = 0; n_err_m = 0; ecnt_m = 0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mem_adr", 32'(mem_adr), 0);
      chk("rst_mem_dat", 32'(mem_dat), 0);
      chk("rst_done_err", {30'd0, done, err}, 0);
      chk("rst_err_cnt", 32'(err_cnt), 0);
      chk("rst_instr_cnt", 32'(instr_cnt), 0);
      #1 sys_rst_n = 1;

      // 1: base load then ADD, zero-wait acks
      load(16'h0100);
      send(D16_OP_ADD, 16'd1, 16'd2, 16'd3);
      check_all("t1");

      // 2: AFC with 3 wait cycles per beat
      ack_delay = 3;
      send(D16_OP_AFC, 16'd5, 16'h1234, 16'd0);
      check_all("t2");

      // 3: JMZ then STP back to back, no idle gap between them
      ack_delay = 0; max_run = 0;
      send(D16_OP_JMZ, 16'hBEEF, 16'd7, 16'd0);
      send(D16_OP_STP, 16'hFFFE, 16'd1, 16'd2);
      check_all("t3");
      chk("t3_no_gap", 32'(max_run), 32'd4);

      // 4: illegal operand and unknown opcode
      send(D16_OP_ADD, 16'h0100, 16'd0, 16'd0);
      send(8'hEE, 16'd0, 16'd0, 16'd0);
      check_all("t4");

      // 4b: ECW=2 counter saturates after five rejects
      @(negedge clk); in_op = 8'hEE; in_valid2 = 1;
      repeat (5) @(posedge clk);
      #1 in_valid2 = 0;
      @(negedge clk);
      chk("t4_ecw2_sat", 32'(err_cnt2), 32'd3);
      chk("t4_ecw2_we", 32'(mem_we2), 32'd0);

      // 5: pointer wrap across the top of memory
      load(16'hFFFF);
      send(D16_OP_JMP, 16'h0040, 16'd0, 16'd0);
      send(D16_OP_OR, 16'd9, 16'd8, 16'd7);
      check_all("t5");

      // Random mix with random ack latency
      for (int i = 0; i < 60; i++) begin
         ack_delay = $urandom_range(0, 2);
         if (i % 20 == 19) begin wait_idle(); load(16'($urandom)); end
         send(op_tab[$urandom_range(0, 21)], rnd_opnd(), rnd_opnd(), rnd_opnd());
      end
      check_all("rnd");

      // 6: reset while HI is waiting for ack
      ack_delay = 20;
      send(D16_OP_LOD, 16'd3, 16'hABCD, 16'd0);
      @(negedge clk);
      chk("t6_we_before", 32'(mem_we), 32'd1);
      #1 sys_rst_n = 0;
      #1;
      chk("t6_we_async", 32'(mem_we), 32'd0);
      @(negedge clk); #1 sys_rst_n = 1;
      #1;
      chk("t6_ready", 32'(in_ready), 32'd1);
      chk("t6_adr_dat", {mem_adr, mem_dat}, 32'd0);
      chk("t6_cnts", {8'd0, err_cnt, instr_cnt}, 32'd0);
      chk("t6_pulses", {30'd0, done, err}, 32'd0);
      got_q.delete(); exp_q.delete();
      ptr_m = 0; n_done_m = 0; n_err_m = 0; ecnt_m = 0;
      done_seen = 0; err_seen = 0; ack_delay = 0;
      send(D16_OP_SUB, 16'd4, 16'd5, 16'd6);
      check_all("t6_after");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/d16_encode.md
Name: d16_encode

Overview:
- Instruction encoder and loader for the d16 core; it performs the inverse of the instruction decode.
- Accepts one instruction in field form per handshake: opcode plus three 16-bit operands, the same shape the decode stage produces.
- Range-checks the operands against the opcode's field layout, packs a legal instruction into a 32-bit word, and writes it into instruction memory as two 16-bit beats.
- Used by the debug/boot loader path to fill program memory.

Parameters:
AW, 16, instruction-memory halfword address width.
ECW, 8, width of the saturating error counter.

Ports:
sys_clk  input  1  core clock.
sys_rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  field-form instruction present.
in_ready  output  1  encoder accepts the instruction this cycle.
in_op  input  8  opcode (D16_OP_*).
in_a  input  16  operand a.
in_b  input  16  operand b.
in_c  input  16  operand c.
adr_load  input  1  load write pointer from adr_base.
adr_base  input  AW  new write pointer.
mem_adr  output  AW  halfword write address.
mem_dat  output  16  write data.
mem_we  output  1  write request, held until ack.
mem_ack  input  1  write accepted this cycle.
done  output  1  one-cycle pulse: both halfwords written.
err  output  1  one-cycle pulse: instruction rejected.
err_cnt  output  ECW  saturating rejected-instruction count.
instr_cnt  output  16  wrapping count of written instructions.

Behaviour:
- Reset (async, sys_rst_n=0):
  - State IDLE; write pointer = 0.
  - mem_we=0, mem_adr=0, mem_dat=0.
  - done=0, err=0, err_cnt=0, instr_cnt=0.
  - A write in flight is abandoned; nothing resumes after reset.
- Packing and legality. word[31:24]=in_op in all cases. "8-bit" means the operand's upper byte is 0; "s8" means the operand equals the sign-extension of its low byte.
  - ADD, SUB, SHL, SHR, OR, AND, EQU, LTE, GTE, LT, GT: a, b, c each 8-bit; word = {op, a[7:0], b[7:0], c[7:0]}.
  - COP: a and b 8-bit, c must be 0; word = {op, a[7:0], b[7:0], 8'h00}.
  - AFC, LOD: a 8-bit, b any value, c must be 0; word = {op, a[7:0], b[15:0]}.
  - STR, JMZ: a any value, b 8-bit, c must be 0; word = {op, a[15:0], b[7:0]}.
  - JMP: b and c must be 0; word = {op, a[15:0], 8'h00}.
  - JMR: a and c must be 0, b 8-bit; word = {op, b[7:0], 16'h0000}.
  - STP: a s8, b and c 8-bit; word = {op, a[7:0], b[7:0], c[7:0]}.
  - LOP: a 8-bit, b s8, c 8-bit; word = {op, a[7:0], b[7:0], c[7:0]}.
  - Any other opcode is illegal.
- State machine: IDLE, HI, LO.
  - in_ready = (IDLE & ~adr_load) | (LO & mem_ack & ~adr_load). The combinational mem_ack -> in_ready path is intended.
  - Accept, legal instruction: latch the word, go to HI.
  - Accept, illegal instruction: err=1 on the next cycle; err_cnt increments, saturating at all-ones; state stays IDLE (or goes IDLE from LO); nothing is written.
  - HI: mem_we=1, mem_adr=ptr, mem_dat=word[31:16]. On mem_ack, go to LO with mem_adr=ptr+1 and mem_dat=word[15:0].
  - LO: on mem_ack, ptr += 2 (wraps modulo 2^AW, as does ptr+1), done=1 next cycle, instr_cnt++ (wrapping).
    - If a legal instruction is accepted in the same cycle, go directly to HI.
    - If an illegal instruction is accepted in the same cycle, go to IDLE with both done and err pulsing.
    - Otherwise go to IDLE.
  - mem_adr, mem_dat and mem_we are registered and stable while waiting for ack. Without wait states, sustained throughput is 1 instruction per 2 cycles.
  - adr_load is honoured only in IDLE and in the final LO-ack cycle; it overrides that cycle's +2 increment. At any other time it is ignored.
- Latency: input accepted at cycle T -> first mem_we at T+1 -> done at Tack_lo+1.

Decomposition:
- Opcode constants come from the existing shared d16.vh header.
- Add to that header the field-layout class constants D16_FMT_RRR, RR, RI16, A16R, A16, R, and the STP/LOP variants, with a single opcode -> format mapping function shared with decode.
- Natural sub-module: d16_encode_pack, purely combinational (op, a, b, c -> word, legal).
- The FSM, pointer and counters stay in d16_encode.

Test Plan:
1. Reset, adr_load with base 0x0100, then ADD a=1,b=2,c=3 with mem_ack tied 1 -> writes 0x0100={OP_ADD,01}, 0x0101=0x0203; done pulses once; instr_cnt=1; ptr=0x0102.
2. AFC a=5, b=0x1234 with mem_ack delayed 3 cycles per beat -> mem_adr, mem_dat and mem_we held stable; words {OP_AFC,05} and 0x1234.
3. JMZ a=0xBEEF,b=7; then STP a=0xFFFE,b=1,c=2 back-to-back -> 0xBEEF07 packed correctly; STP low byte 0xFE; no IDLE gap between the two instructions.
4. Illegal ADD a=0x0100, then an unknown opcode -> err pulses twice, err_cnt=2, no mem_we; with ECW=2, five illegal instructions leave err_cnt=3.
5. Pointer at 2^AW-1, write JMP a=0x0040 -> high half at max address, low half at address 0; ptr wraps to 1.
6. Assert sys_rst_n low during HI while waiting for ack -> mem_we drops immediately; after release all outputs are 0, state is IDLE, and in_ready=1.
